// File: rtl/nn_argmax_unit_if.sv
// Score stream between the output neuron layer and the argmax unit.
interface nn_argmax_unit_if #(
  parameter int DATA_W = 32
);
  logic                     in_valid;
  logic signed [DATA_W-1:0] in_data;
  logic                     in_ready;

  modport master (output in_valid, output in_data, input  in_ready);
  modport slave  (input  in_valid, input  in_data, output in_ready);
endinterface

// File: rtl/nn_argmax_unit.sv
// Streaming argmax over one inference worth of signed class scores.
// argmax_output only updates on DONE entry, abort or reset; 10 means "no result".
module nn_argmax_unit #(
  parameter int NUM_CLASSES = 10,
  parameter int DATA_W      = 32,
  parameter int IDX_W       = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     abort,
  nn_argmax_unit_if.slave          s,
  output logic [IDX_W-1:0]         argmax_output,
  output logic signed [DATA_W-1:0] max_value,
  output logic                     busy,
  output logic                     done,
  output logic [1:0]               current_state
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  localparam logic [IDX_W-1:0] NO_RESULT = IDX_W'(10);
  localparam logic [IDX_W-1:0] LAST      = IDX_W'(NUM_CLASSES - 1);

  state_t                   state, state_nxt;
  logic                     start_q, start_rise, accept, last_beat, take;
  logic [IDX_W-1:0]         count, best_idx, win_idx;
  logic signed [DATA_W-1:0] best_val, win_val;

  // Winner including the current beat; beat 0 always seeds the running max.
  always_comb begin
    start_rise = start & ~start_q;
    accept     = s.in_valid & s.in_ready & ~abort;
    last_beat  = (count == LAST);
    take       = (count == '0) || (s.in_data > best_val);
    win_idx    = take ? count : best_idx;
    win_val    = take ? s.in_data : best_val;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    s.in_ready = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: if (start_rise) state_nxt = RUN;
      RUN: begin
        s.in_ready = 1'b1;
        busy       = 1'b1;
        if (accept && last_beat) state_nxt = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (start_rise) state_nxt = RUN;
      end
      default: state_nxt = IDLE;
    endcase
    if (abort) state_nxt = IDLE;
  end

  assign current_state = state;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      start_q       <= 1'b0;
      count         <= '0;
      best_idx      <= '0;
      best_val      <= '0;
      argmax_output <= NO_RESULT;
      max_value     <= '0;
    end else begin
      start_q <= start;
      if (abort) begin
        count         <= '0;
        best_idx      <= '0;
        best_val      <= '0;
        argmax_output <= NO_RESULT;
        max_value     <= '0;
      end else if (state != RUN) begin
        if (start_rise) begin
          count    <= '0;
          best_idx <= '0;
          best_val <= '0;
        end
      end else if (accept) begin
        count    <= count + IDX_W'(1);
        best_idx <= win_idx;
        best_val <= win_val;
        if (last_beat) begin
          argmax_output <= win_idx;
          max_value     <= win_val;
        end
      end
    end
  end

endmodule

// File: tb/tb_nn_argmax_unit.sv
// Directed bench for nn_argmax_unit: reset, basic, signed, gaps/start, abort, async reset, last beat.
module tb_nn_argmax_unit;
  typedef int vec_t [10];

  logic                clk = 1'b0;
  logic                reset, start, abort;
  logic [3:0]          argmax_output;
  logic signed [31:0]  max_value;
  logic                busy, done;
  logic [1:0]          current_state;
  int                  checks = 0;
  int                  errs   = 0;
  int                  rdy_cnt = 0;

  nn_argmax_unit_if #(.DATA_W(32)) sif ();

  nn_argmax_unit #(.NUM_CLASSES(10), .DATA_W(32), .IDX_W(4)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .s(sif),
    .argmax_output(argmax_output), .max_value(max_value),
    .busy(busy), .done(done), .current_state(current_state)
  );

  always #5 clk = ~clk;
  always @(negedge clk) if (sif.in_ready === 1'b1) rdy_cnt++;

  vec_t v_basic = '{5, -3, 12, 7, 0, 1, 2, 12, 4, -9};
  vec_t v_neg   = '{-100, -50, -7, -8, -200, -9, -60, -70, -80, -90};
  vec_t v_six   = '{1, 2, 3, 4, 5, 6, 50, 7, 8, 9};
  vec_t v_last  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1};

  // Produces a fresh start rise; leaves start high when keep is set.
  task automatic pulse_start(input bit keep);
    start = 1'b0;
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    if (!keep) start = 1'b0;
  endtask

  // Streams the first n beats of v; returns #1 after the last handshake edge.
  task automatic feed(input vec_t v, input int n, input bit gaps);
    for (int i = 0; i < n; i++) begin
      if (gaps) begin
        int g = $urandom_range(0, 3);
        for (int j = 0; j < g; j++) begin
          sif.in_valid = 1'b0;
          @(posedge clk); #1;
        end
      end
      sif.in_valid = 1'b1;
      sif.in_data  = v[i];
      @(posedge clk); #1;
      sif.in_valid = 1'b0;
      sif.in_data  = 32'sd0;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b0; abort = 1'b0;
    sif.in_valid = 1'b0; sif.in_data = 32'sd0;
    #12;
    checks++; if (argmax_output !== 4'd10) begin errs++; $display("FAIL reset_argmax got=%0d exp=10", argmax_output); end
    checks++; if (max_value !== 32'sd0) begin errs++; $display("FAIL reset_max got=%0d exp=0", max_value); end
    checks++; if ({sif.in_ready, busy, done} !== 3'b000) begin errs++; $display("FAIL reset_flags got=%b exp=000", {sif.in_ready, busy, done}); end
    checks++; if (current_state !== 2'd0) begin errs++; $display("FAIL reset_state got=%0d exp=0", current_state); end
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1;
    checks++; if (current_state !== 2'd0) begin errs++; $display("FAIL idle_no_start got=%0d exp=0", current_state); end
  endtask

  task automatic test_basic();
    rdy_cnt = 0;
    pulse_start(1'b0);
    checks++; if ({current_state, busy, sif.in_ready} !== 4'b0111) begin errs++; $display("FAIL basic_run got=%b exp=0111", {current_state, busy, sif.in_ready}); end
    feed(v_basic, 9, 1'b0);
    checks++; if (argmax_output !== 4'd10 || done !== 1'b0) begin errs++; $display("FAIL basic_no_early got=%0d/%b exp=10/0", argmax_output, done); end
    feed(v_basic, 1, 1'b0);
    sif.in_data = v_basic[9];
    feed('{-9, 0, 0, 0, 0, 0, 0, 0, 0, 0}, 0, 1'b0);
    checks++; if (done !== 1'b1 || current_state !== 2'd2) begin errs++; $display("FAIL basic_done got=%b/%0d exp=1/2", done, current_state); end
    checks++; if (argmax_output !== 4'd2) begin errs++; $display("FAIL basic_argmax got=%0d exp=2", argmax_output); end
    checks++; if (max_value !== 32'sd12) begin errs++; $display("FAIL basic_max got=%0d exp=12", max_value); end
    repeat (3) @(posedge clk); #1;
    checks++; if (rdy_cnt != 10) begin errs++; $display("FAIL basic_ready_cycles got=%0d exp=10", rdy_cnt); end
    checks++; if ({sif.in_ready, busy, done} !== 3'b001) begin errs++; $display("FAIL basic_hold got=%b exp=001", {sif.in_ready, busy, done}); end
  endtask

  task automatic test_negative();
    pulse_start(1'b0);
    feed(v_neg, 10, 1'b0);
    checks++; if (argmax_output !== 4'd2) begin errs++; $display("FAIL neg_argmax got=%0d exp=2", argmax_output); end
    checks++; if (max_value !== -32'sd7) begin errs++; $display("FAIL neg_max got=%0d exp=-7", max_value); end
  endtask

  task automatic test_backpressure();
    pulse_start(1'b1);
    feed(v_basic, 10, 1'b1);
    checks++; if (argmax_output !== 4'd2 || max_value !== 32'sd12) begin errs++; $display("FAIL bp_result got=%0d/%0d exp=2/12", argmax_output, max_value); end
    repeat (6) @(posedge clk); #1;
    checks++; if (current_state !== 2'd2 || done !== 1'b1) begin errs++; $display("FAIL bp_no_rerun got=%0d/%b exp=2/1", current_state, done); end
    pulse_start(1'b0);
    checks++; if (current_state !== 2'd1 || done !== 1'b0) begin errs++; $display("FAIL bp_restart got=%0d/%b exp=1/0", current_state, done); end
    checks++; if (argmax_output !== 4'd2) begin errs++; $display("FAIL bp_old_kept got=%0d exp=2", argmax_output); end
    start = 1'b1;
    feed(v_last, 5, 1'b1);
    checks++; if (current_state !== 2'd1) begin errs++; $display("FAIL bp_start_in_run got=%0d exp=1", current_state); end
    start = 1'b0;
    for (int i = 5; i < 10; i++) begin
      sif.in_valid = 1'b1; sif.in_data = v_last[i];
      @(posedge clk); #1;
    end
    sif.in_valid = 1'b0;
    checks++; if (argmax_output !== 4'd9 || max_value !== 32'sd1) begin errs++; $display("FAIL bp_second got=%0d/%0d exp=9/1", argmax_output, max_value); end
  endtask

  task automatic test_abort();
    pulse_start(1'b0);
    feed(v_six, 10, 1'b0);
    checks++; if (argmax_output !== 4'd6 || max_value !== 32'sd50) begin errs++; $display("FAIL abort_prev got=%0d/%0d exp=6/50", argmax_output, max_value); end
    pulse_start(1'b0);
    feed(v_six, 4, 1'b0);
    abort = 1'b1; sif.in_valid = 1'b1; sif.in_data = 32'sd1000;
    #1;
    checks++; if (sif.in_ready !== 1'b1) begin errs++; $display("FAIL abort_ready_cycle got=%b exp=1", sif.in_ready); end
    @(posedge clk); #1;
    abort = 1'b0; sif.in_valid = 1'b0;
    checks++; if (current_state !== 2'd0 || done !== 1'b0 || busy !== 1'b0) begin errs++; $display("FAIL abort_idle got=%0d/%b/%b exp=0/0/0", current_state, done, busy); end
    checks++; if (argmax_output !== 4'd10 || max_value !== 32'sd0) begin errs++; $display("FAIL abort_clear got=%0d/%0d exp=10/0", argmax_output, max_value); end
    pulse_start(1'b0);
    feed(v_neg, 10, 1'b0);
    checks++; if (argmax_output !== 4'd2 || max_value !== -32'sd7) begin errs++; $display("FAIL abort_fresh got=%0d/%0d exp=2/-7", argmax_output, max_value); end
  endtask

  task automatic test_reset_mid();
    pulse_start(1'b0);
    feed(v_six, 7, 1'b0);
    sif.in_valid = 1'b1; sif.in_data = v_six[7];
    #2 reset = 1'b0;
    #1;
    checks++; if (argmax_output !== 4'd10 || max_value !== 32'sd0) begin errs++; $display("FAIL rst_mid_out got=%0d/%0d exp=10/0", argmax_output, max_value); end
    checks++; if ({sif.in_ready, busy, done, current_state} !== 5'b00000) begin errs++; $display("FAIL rst_mid_flags got=%b exp=00000", {sif.in_ready, busy, done, current_state}); end
    sif.in_valid = 1'b0;
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1;
    checks++; if (current_state !== 2'd0) begin errs++; $display("FAIL rst_mid_idle got=%0d exp=0", current_state); end
  endtask

  task automatic test_last_beat();
    pulse_start(1'b0);
    feed(v_last, 10, 1'b0);
    checks++; if (argmax_output !== 4'd9 || done !== 1'b1) begin errs++; $display("FAIL last_argmax got=%0d/%b exp=9/1", argmax_output, done); end
    checks++; if (max_value !== 32'sd1) begin errs++; $display("FAIL last_max got=%0d exp=1", max_value); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_negative();
    test_backpressure();
    test_abort();
    test_reset_mid();
    test_last_beat();
    $display("TB_RESULT checks=%0d failures=%0d", checks, errs);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule
